// File: rtl/pc_control.sv
// Next-PC controller: owns the architectural PC and exception PC, and resolves
// sequential flow, branches/jumps, RTI, exception vectoring, stall and halt.
module pc_control #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [2:0]  pc_code,
    input  logic [15:0] target_pc,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        exc_req,
    output logic [15:0] curr_pc,
    output logic [15:0] pc2,
    output logic [15:0] epc,
    output logic        fetch_en,
    output logic        halted,
    output logic        in_exc,
    output logic        illegal_code
);

    typedef enum logic [1:0] {StRun, StVector, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] curr_pc_q, curr_pc_d;
    logic [15:0] epc_q, epc_d;
    logic        in_exc_q, in_exc_d;
    logic        illegal_q, illegal_d;

    logic commit;
    logic bad_code;
    logic misaligned;
    logic take_exc;

    assign pc2    = curr_pc_q + 16'd2;
    assign commit = (state_q == StRun) && instr_valid && !stall;

    // RTI outside handler mode is just another illegal code.
    assign bad_code   = (pc_code >= 3'b101) || ((pc_code == 3'b100) && !in_exc_q);
    assign misaligned = target_pc[0] && (pc_code >= 3'b001) && (pc_code <= 3'b011);
    assign take_exc   = exc_req || bad_code || misaligned;

    always_comb begin
        state_d   = state_q;
        curr_pc_d = curr_pc_q;
        epc_d     = epc_q;
        in_exc_d  = in_exc_q;
        illegal_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (commit) begin
                    if (halt_req) begin
                        state_d = StHalt;
                    end else if (take_exc) begin
                        illegal_d = bad_code || misaligned;
                        if (!in_exc_q) begin
                            epc_d     = pc2;
                            curr_pc_d = EXC_VECTOR;
                            in_exc_d  = 1'b1;
                            state_d   = StVector;
                        end else begin
                            // Fault inside the handler: nothing safe to return to.
                            state_d = StHalt;
                        end
                    end else if (pc_code == 3'b100) begin
                        curr_pc_d = epc_q;
                        in_exc_d  = 1'b0;
                    end else if (pc_code == 3'b000) begin
                        curr_pc_d = pc2;
                    end else begin
                        curr_pc_d = target_pc;
                    end
                end
            end
            StVector: state_d = StRun;
            StHalt:   state_d = StHalt;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StRun;
            curr_pc_q <= RESET_PC;
            epc_q     <= 16'h0000;
            in_exc_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            curr_pc_q <= curr_pc_d;
            epc_q     <= epc_d;
            in_exc_q  <= in_exc_d;
            illegal_q <= illegal_d;
        end
    end

    assign curr_pc      = curr_pc_q;
    assign epc          = epc_q;
    assign in_exc       = in_exc_q;
    assign illegal_code = illegal_q;
    assign fetch_en     = (state_q == StRun);
    assign halted       = (state_q == StHalt);

endmodule

// File: tb/tb_pc_control.sv
// Scoreboard bench for pc_control: the driver queues hand-computed expectations,
// the monitor pops and compares one entry after every rising edge.
module tb_pc_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [2:0]  pc_code;
    logic [15:0] target_pc;
    logic        stall;
    logic        halt_req;
    logic        exc_req;

    logic [15:0] curr_pc, pc2, epc;
    logic        fetch_en, halted, in_exc, illegal_code;
    logic [15:0] curr_pc_b, pc2_b, epc_b;
    logic        fetch_en_b, halted_b, in_exc_b, illegal_code_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] epc;
        logic        fe;
        logic        hl;
        logic        ie;
        logic        il;
        logic        chk_b;
        logic [15:0] pc_b;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_control dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc_code(pc_code),
        .target_pc(target_pc), .stall(stall), .halt_req(halt_req), .exc_req(exc_req),
        .curr_pc(curr_pc), .pc2(pc2), .epc(epc), .fetch_en(fetch_en), .halted(halted),
        .in_exc(in_exc), .illegal_code(illegal_code)
    );

    pc_control #(.RESET_PC(16'hFFFC), .EXC_VECTOR(16'h0002)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc_code(pc_code),
        .target_pc(target_pc), .stall(stall), .halt_req(halt_req), .exc_req(exc_req),
        .curr_pc(curr_pc_b), .pc2(pc2_b), .epc(epc_b), .fetch_en(fetch_en_b),
        .halted(halted_b), .in_exc(in_exc_b), .illegal_code(illegal_code_b)
    );

    task automatic check16(input string nm, input string fld, input logic [15:0] act,
                           input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
        end
    endtask

    task automatic check1(input string nm, input string fld, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %b, expected %b", nm, fld, act, req);
        end
    endtask

    // Monitor: the DUT presents new state after every rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [15:0] pc2_exp;
            e = exp_q.pop_front();
            pc2_exp = e.pc + 16'd2;
            check16(e.name, "curr_pc", curr_pc, e.pc);
            check16(e.name, "pc2", pc2, pc2_exp);
            check16(e.name, "epc", epc, e.epc);
            check1(e.name, "fetch_en", fetch_en, e.fe);
            check1(e.name, "halted", halted, e.hl);
            check1(e.name, "in_exc", in_exc, e.ie);
            check1(e.name, "illegal_code", illegal_code, e.il);
            if (e.chk_b) begin
                pc2_exp = e.pc_b + 16'd2;
                check16(e.name, "curr_pc_b", curr_pc_b, e.pc_b);
                check16(e.name, "pc2_b", pc2_b, pc2_exp);
            end
        end
    end

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic cyc(input string nm, input logic rn, input logic v, input logic [2:0] c,
                       input logic [15:0] t, input logic s, input logic h, input logic x,
                       input logic [15:0] pc, input logic [15:0] ep, input logic fe,
                       input logic hl, input logic ie, input logic il,
                       input logic chk_b = 1'b0, input logic [15:0] pc_b = 16'h0000);
        exp_t e;
        @(negedge clk);
        rst_n = rn; instr_valid = v; pc_code = c; target_pc = t;
        stall = s; halt_req = h; exc_req = x;
        e.name = nm; e.pc = pc; e.epc = ep; e.fe = fe; e.hl = hl; e.ie = ie; e.il = il;
        e.chk_b = chk_b; e.pc_b = pc_b;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; pc_code = 3'b000; target_pc = 16'h0000;
        stall = 1'b0; halt_req = 1'b0; exc_req = 1'b0;

        // Reset and sequential flow, both reset values
        cyc("rst0", 0, 1, 3'b000, 16'h0000, 0, 1, 1, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 16'hFFFC);
        cyc("rst1", 0, 1, 3'b000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 16'hFFFC);
        cyc("seq1", 1, 1, 3'b000, 16'h0000, 0, 0, 0, 16'h0002, 16'h0000, 1, 0, 0, 0, 1, 16'hFFFE);
        cyc("seq2", 1, 1, 3'b000, 16'h0000, 0, 0, 0, 16'h0004, 16'h0000, 1, 0, 0, 0, 1, 16'h0000);
        cyc("novalid", 1, 0, 3'b011, 16'h0100, 0, 1, 1, 16'h0004, 16'h0000, 1, 0, 0, 0);

        // Jumps and stall
        cyc("jmp10", 1, 1, 3'b011, 16'h0010, 0, 0, 0, 16'h0010, 16'h0000, 1, 0, 0, 0);
        cyc("jmp40", 1, 1, 3'b011, 16'h0040, 0, 0, 0, 16'h0040, 16'h0000, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("stall", 1, 1, 3'b010, 16'h0100, 1, 0, 0, 16'h0040, 16'h0000, 1, 0, 0, 0);
        cyc("unstall", 1, 1, 3'b010, 16'h0100, 0, 0, 0, 16'h0100, 16'h0000, 1, 0, 0, 0);

        // Exception entry and RTI
        cyc("br20", 1, 1, 3'b001, 16'h0020, 0, 0, 0, 16'h0020, 16'h0000, 1, 0, 0, 0);
        cyc("exc", 1, 1, 3'b000, 16'h0000, 0, 0, 1, 16'h0002, 16'h0022, 0, 0, 1, 0);
        cyc("vector", 1, 1, 3'b011, 16'h0200, 0, 1, 1, 16'h0002, 16'h0022, 1, 0, 1, 0);
        cyc("rti", 1, 1, 3'b100, 16'h0000, 0, 0, 0, 16'h0022, 16'h0022, 1, 0, 0, 0);

        // Illegal code, misaligned target, double fault
        cyc("jmp30", 1, 1, 3'b011, 16'h0030, 0, 0, 0, 16'h0030, 16'h0022, 1, 0, 0, 0);
        cyc("ill110", 1, 1, 3'b110, 16'h0000, 0, 0, 0, 16'h0002, 16'h0032, 0, 0, 1, 1);
        cyc("ill_vec", 1, 1, 3'b000, 16'h0000, 0, 0, 0, 16'h0002, 16'h0032, 1, 0, 1, 0);
        cyc("rti2", 1, 1, 3'b100, 16'h0000, 0, 0, 0, 16'h0032, 16'h0032, 1, 0, 0, 0);
        cyc("jmp50", 1, 1, 3'b011, 16'h0050, 0, 0, 0, 16'h0050, 16'h0032, 1, 0, 0, 0);
        cyc("misalign", 1, 1, 3'b011, 16'h0041, 0, 0, 0, 16'h0002, 16'h0052, 0, 0, 1, 1);
        cyc("mis_vec", 1, 1, 3'b000, 16'h0000, 0, 0, 0, 16'h0002, 16'h0052, 1, 0, 1, 0);
        cyc("dfault", 1, 1, 3'b000, 16'h0000, 0, 0, 1, 16'h0002, 16'h0052, 0, 1, 1, 0);
        cyc("rst2", 0, 1, 3'b000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0);

        // RTI outside the handler is illegal
        cyc("rti_ill", 1, 1, 3'b100, 16'h0000, 0, 0, 0, 16'h0002, 16'h0002, 0, 0, 1, 1);
        cyc("rti_vec", 1, 1, 3'b000, 16'h0000, 0, 0, 0, 16'h0002, 16'h0002, 1, 0, 1, 0);
        cyc("rti3", 1, 1, 3'b100, 16'h0000, 0, 0, 0, 16'h0002, 16'h0002, 1, 0, 0, 0);

        // Halt beats exception, stays sticky until reset
        cyc("jmp60", 1, 1, 3'b011, 16'h0060, 0, 0, 0, 16'h0060, 16'h0002, 1, 0, 0, 0);
        cyc("halt", 1, 1, 3'b000, 16'h0000, 0, 1, 1, 16'h0060, 16'h0002, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            logic [2:0] c;
            c = 3'(i);
            cyc("halt_hold", 1, 1, c, 16'h0101 + 16'(i), i[0], i[1], i[2],
                16'h0060, 16'h0002, 0, 1, 0, 0);
        end
        cyc("rst3", 0, 1, 3'b000, 16'h0000, 0, 1, 1, 16'h0000, 16'h0000, 1, 0, 0, 0);

        // Reset during the vector cycle
        cyc("exc2", 1, 1, 3'b000, 16'h0000, 0, 0, 1, 16'h0002, 16'h0002, 0, 0, 1, 0);
        cyc("rst_vec", 0, 1, 3'b000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0);
        cyc("post_rst", 1, 1, 3'b000, 16'h0000, 0, 0, 0, 16'h0002, 16'h0000, 1, 0, 0, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
